flag_branch_resolver: RTL

Consumer-side counterpart of the 3-bit flag register. It accepts a branch from decode, drives the flag register read enable, and samples the flag bitlines. Flag writes landing in the same cycle are bypassed in. It then evaluates the branch condition and returns a registered taken/target/flush result to the fetch stage. Flag order everywhere is bit2 Z, bit1 V, bit0 N.

---
 rtl/flag_branch_resolver.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/flag_branch_resolver.sv
// Branch resolver: reads the 3-bit flag register (Z,V,N), merges same-cycle flag writes,
// evaluates the branch condition and returns a registered taken/target/flush result.
// Optional BRANCH_STATS_EN adds saturating stat_total/stat_taken counters.
module flag_branch_resolver #(
   parameter int ADDR_W   = 16,
   parameter int IMM_W    = 9,
   parameter int MAX_WAIT = 15
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    br_valid,
   output logic                    br_ready,
   input  logic [2:0]              br_cond,
   input  logic                    br_is_reg,
   input  logic [ADDR_W-1:0]       pc_plus2,
   input  logic signed [IMM_W-1:0] br_imm,
   input  logic [ADDR_W-1:0]       reg_target,
   output logic                    flag_read_en,
   input  logic [2:0]              flags_in,
   input  logic [2:0]              alu_flag_we,
   input  logic [2:0]              alu_flag_d,
   input  logic                    flag_busy,
   output logic                    br_done,
   output logic                    br_taken,
   output logic [ADDR_W-1:0]       br_target,
   output logic                    flush,
   output logic                    wait_timeout
`ifdef BRANCH_STATS_EN
   ,
   output logic [15:0]             stat_total,
   output logic [15:0]             stat_taken
`endif
);

   localparam int CNT_W = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [2:0]              cond_p0;
   logic                    is_reg_p0;
   logic [ADDR_W-1:0]       pc_p0;
   logic signed [IMM_W-1:0] imm_p0;
   logic [ADDR_W-1:0]       reg_tgt_p0;

   logic                    taken_p1;
   logic [ADDR_W-1:0]       target_p1;

   logic [CNT_W-1:0]        wait_cnt;
   logic                    timeout_q;

   logic                    at_limit;
   logic [2:0]              merged_flags;
   logic                    resolved_taken;
   logic [ADDR_W-1:0]       resolved_target;

   // Bitline value with any flag write landing this cycle taking priority.
   function automatic logic [2:0] merge_flags(input logic [2:0] flags,
                                              input logic [2:0] we,
                                              input logic [2:0] d);
      logic [2:0] m;
      for (int i = 0; i < 3; i++) begin
         m[i] = we[i] ? d[i] : flags[i];
      end
      return m;
   endfunction

   // Flag order is {Z, V, N}.
   function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] f);
      logic z, v, n;
      z = f[2];
      v = f[1];
      n = f[0];
      case (cond)
         3'b000:  return !z;
         3'b001:  return z;
         3'b010:  return !z && !n;
         3'b011:  return n;
         3'b100:  return z || (!z && !n);
         3'b101:  return n || z;
         3'b110:  return v;
         default: return 1'b1;
      endcase
   endfunction

   // Halfword offset: sign-extend, scale by two, wrap modulo 2^ADDR_W.
   function automatic logic [ADDR_W-1:0] rel_target(input logic [ADDR_W-1:0] pc,
                                                     input logic signed [IMM_W-1:0] imm);
      logic signed [ADDR_W-1:0] ext;
      ext = {{(ADDR_W - IMM_W){imm[IMM_W-1]}}, imm};
      return pc + {ext[ADDR_W-2:0], 1'b0};
   endfunction

   assign at_limit        = flag_busy && (wait_cnt == CNT_W'(MAX_WAIT - 1));
   assign merged_flags    = merge_flags(flags_in, alu_flag_we, alu_flag_d);
   assign resolved_taken  = cond_met(cond_p0, merged_flags);
   assign resolved_target = !resolved_taken ? pc_p0 :
                            is_reg_p0       ? reg_tgt_p0 :
                                              rel_target(pc_p0, imm_p0);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (br_valid) state_nxt = READ;
         READ:    if (!flag_busy || at_limit) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      br_ready     = (state == IDLE);
      flag_read_en = (state == READ);
      br_done      = (state == RESP);
      br_taken     = br_done && taken_p1;
      flush        = br_done && taken_p1;
      br_target    = br_done ? target_p1 : '0;
   end

   assign wait_timeout = timeout_q;

   // Stage p0: request capture at accept.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cond_p0    <= '0;
         is_reg_p0  <= 1'b0;
         pc_p0      <= '0;
         imm_p0     <= '0;
         reg_tgt_p0 <= '0;
      end else if (state == IDLE && br_valid) begin
         cond_p0    <= br_cond;
         is_reg_p0  <= br_is_reg;
         pc_p0      <= pc_plus2;
         imm_p0     <= br_imm;
         reg_tgt_p0 <= reg_target;
      end
   end

   // Stage p1: resolution while reading flags, or forced not-taken on timeout.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         taken_p1  <= 1'b0;
         target_p1 <= '0;
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else if (state == READ) begin
         if (at_limit) begin
            taken_p1  <= 1'b0;
            target_p1 <= pc_p0;
            wait_cnt  <= '0;
            timeout_q <= 1'b1;
         end else if (flag_busy) begin
            wait_cnt <= wait_cnt + 1'b1;
         end else begin
            taken_p1  <= resolved_taken;
            target_p1 <= resolved_target;
            wait_cnt  <= '0;
         end
      end
   end

`ifdef BRANCH_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_total <= '0;
         stat_taken <= '0;
      end else if (state == RESP) begin
         if (stat_total != 16'hFFFF) stat_total <= stat_total + 16'd1;
         if (taken_p1 && stat_taken != 16'hFFFF) stat_taken <= stat_taken + 16'd1;
      end
   end
`endif

endmodule
